// File: rtl/cnu_minsum_serial.sv
// Offset min-sum check-node unit: serially collects D variable-to-check messages,
// then serially emits D check-to-variable messages plus the row syndrome.
module cnu_minsum_serial #(
  parameter int DATA_W = 8,
  parameter int D      = 6,
  parameter int IDX_W  = 3,
  parameter int OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              syn,
  output logic              syn_valid
);

  localparam logic [DATA_W-2:0] MAXMAG   = {(DATA_W-1){1'b1}};
  localparam logic [DATA_W-1:0] MOSTNEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-2:0] OFF_M    = (DATA_W-1)'(OFFSET);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(D-1);

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [IDX_W-1:0]    cnt_r, cnt_nxt_s;
  logic [DATA_W-2:0]   min1_r, min1_nxt_s, min2_r, min2_nxt_s;
  logic [IDX_W-1:0]    idx1_r, idx1_nxt_s;
  logic                sgn_tot_r, sgn_tot_nxt_s;
  logic [D-1:0]        sign_r, sign_nxt_s;
  logic                syn_r, syn_nxt_s, syn_valid_r, syn_valid_nxt_s;
  logic                in_ready_r, in_ready_nxt_s;
  logic                out_valid_r, out_valid_nxt_s;
  logic [DATA_W-1:0]   out_data_r, out_data_nxt_s;
  logic [IDX_W-1:0]    out_idx_r, out_idx_nxt_s;
  logic                out_last_r, out_last_nxt_s;
  logic [DATA_W-2:0]   beat_mag_s;
  logic                beat_sgn_s, in_acc_s, out_acc_s;

  // Saturating magnitude: the most negative code maps to MAXMAG.
  function automatic logic [DATA_W-2:0] mag_of(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] neg_s;
    neg_s = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    if (v == MOSTNEG) begin
      mag_of = MAXMAG;
    end else if (v[DATA_W-1]) begin
      mag_of = neg_s[DATA_W-2:0];
    end else begin
      mag_of = v[DATA_W-2:0];
    end
  endfunction

  function automatic logic [DATA_W-1:0] emit_val(
    input logic [IDX_W-1:0]  i,
    input logic [DATA_W-2:0] m1,
    input logic [DATA_W-2:0] m2,
    input logic [IDX_W-1:0]  i1,
    input logic              stot,
    input logic [D-1:0]      signs
  );
    logic [DATA_W-2:0] mag_s;
    logic              sgn_s;
    mag_s = (i == i1) ? m2 : m1;
    if (mag_s > OFF_M) begin
      mag_s = mag_s - OFF_M;
    end else begin
      mag_s = {(DATA_W-1){1'b0}};
    end
    sgn_s = stot ^ signs[i];
    if (sgn_s) begin
      emit_val = {DATA_W{1'b0}} - {1'b0, mag_s};
    end else begin
      emit_val = {1'b0, mag_s};
    end
  endfunction

  assign beat_mag_s = mag_of(in_data);
  assign beat_sgn_s = in_data[DATA_W-1];
  assign in_acc_s   = in_valid && in_ready_r;
  assign out_acc_s  = out_valid_r && out_ready;

  // Next-state and datapath update for both collection and emission.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    min1_nxt_s      = min1_r;
    min2_nxt_s      = min2_r;
    idx1_nxt_s      = idx1_r;
    sgn_tot_nxt_s   = sgn_tot_r;
    sign_nxt_s      = sign_r;
    syn_nxt_s       = syn_r;
    syn_valid_nxt_s = syn_valid_r;
    out_data_nxt_s  = out_data_r;
    out_idx_nxt_s   = out_idx_r;
    out_last_nxt_s  = out_last_r;
    case (state_r)
      COLLECT: begin
        if (in_acc_s) begin
          sign_nxt_s[cnt_r] = beat_sgn_s;
          sgn_tot_nxt_s     = sgn_tot_r ^ beat_sgn_s;
          if (beat_mag_s < min1_r) begin
            min2_nxt_s = min1_r;
            min1_nxt_s = beat_mag_s;
            idx1_nxt_s = cnt_r;
          end else if (beat_mag_s < min2_r) begin
            min2_nxt_s = beat_mag_s;
          end else begin
            min2_nxt_s = min2_r;
          end
          if (cnt_r == LAST_IDX) begin
            cnt_nxt_s       = {IDX_W{1'b0}};
            syn_nxt_s       = sgn_tot_nxt_s;
            syn_valid_nxt_s = 1'b1;
            state_nxt_s     = EMIT;
            out_idx_nxt_s   = {IDX_W{1'b0}};
            out_last_nxt_s  = 1'b0;
            out_data_nxt_s  = emit_val({IDX_W{1'b0}}, min1_nxt_s, min2_nxt_s,
                                       idx1_nxt_s, sgn_tot_nxt_s, sign_nxt_s);
          end else begin
            cnt_nxt_s = cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      EMIT: begin
        if (out_acc_s && out_last_r) begin
          state_nxt_s    = COLLECT;
          min1_nxt_s     = MAXMAG;
          min2_nxt_s     = MAXMAG;
          sgn_tot_nxt_s  = 1'b0;
          cnt_nxt_s      = {IDX_W{1'b0}};
          out_idx_nxt_s  = {IDX_W{1'b0}};
          out_last_nxt_s = 1'b0;
          out_data_nxt_s = {DATA_W{1'b0}};
        end else if (out_acc_s) begin
          out_idx_nxt_s  = out_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          out_last_nxt_s = (out_idx_nxt_s == LAST_IDX);
          out_data_nxt_s = emit_val(out_idx_nxt_s, min1_r, min2_r, idx1_r,
                                    sgn_tot_r, sign_r);
        end else begin
          state_nxt_s = EMIT;
        end
      end
      default: begin
        state_nxt_s = COLLECT;
      end
    endcase
    in_ready_nxt_s  = (state_nxt_s == COLLECT);
    out_valid_nxt_s = (state_nxt_s == EMIT);
  end

  // State and datapath registers; in_ready stays low while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= COLLECT;
      cnt_r       <= {IDX_W{1'b0}};
      min1_r      <= MAXMAG;
      min2_r      <= MAXMAG;
      idx1_r      <= {IDX_W{1'b0}};
      sgn_tot_r   <= 1'b0;
      sign_r      <= {D{1'b0}};
      syn_r       <= 1'b0;
      syn_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_idx_r   <= {IDX_W{1'b0}};
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      min1_r      <= min1_nxt_s;
      min2_r      <= min2_nxt_s;
      idx1_r      <= idx1_nxt_s;
      sgn_tot_r   <= sgn_tot_nxt_s;
      sign_r      <= sign_nxt_s;
      syn_r       <= syn_nxt_s;
      syn_valid_r <= syn_valid_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_idx_r   <= out_idx_nxt_s;
      out_last_r  <= out_last_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;
  assign syn       = syn_r;
  assign syn_valid = syn_valid_r;

endmodule
